// File: rtl/rstseq_pkg.sv
// Shared definitions for the reset sequencer: cause codes, state encoding and a width helper.
package rstseq_pkg;

    typedef logic [1:0] rs_state_t;
    typedef logic [1:0] rst_cause_t;

    localparam rst_cause_t RST_CAUSE_EXT  = 2'd0;
    localparam rst_cause_t RST_CAUSE_LOCK = 2'd1;
    localparam rst_cause_t RST_CAUSE_SW   = 2'd2;
    localparam rst_cause_t RST_CAUSE_WDT  = 2'd3;

    localparam rs_state_t RS_HOLD    = 2'd0;
    localparam rs_state_t RS_RELEASE = 2'd1;
    localparam rs_state_t RS_RUN     = 2'd2;

    // Counter width for a value range, never narrower than one bit.
    function automatic int unsigned clog2_min1(input int unsigned value);
        int unsigned width;
        width = $unsigned($clog2(value));
        return (width < 1) ? 1 : width;
    endfunction

endpackage

// File: rtl/sync_ff2.sv
// Two-flop synchroniser for a single asynchronous level. Deliberately not reset so that
// the sampled level keeps flowing while the sequencer itself is being reset.
module sync_ff2 (
    input  logic clk,
    input  logic d,
    output logic q
);

    logic meta = 1'b0;
    logic sync = 1'b0;

    always_ff @(posedge clk) begin
        meta <= d;
        sync <= meta;
    end

    assign q = sync;

endmodule

// File: rtl/reset_sequencer.sv
// Reset sequencer: qualifies PLL lock, holds all domains, then releases them one by one.
// The watchdog re-trigger is only built when RSTSEQ_WDT_EN is defined.
module reset_sequencer
    import rstseq_pkg::*;
#(
    parameter int unsigned N_OUT       = 4,
    parameter int unsigned HOLD_CYCLES = 22'h3fffff,
    parameter int unsigned STAGGER     = 16,
    parameter int unsigned WDT_W       = 20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pll_lock,
    input  logic             sw_rst_req,
    input  logic             wdt_en,
    input  logic             wdt_kick,
    output logic [N_OUT-1:0] rst_out,
    output logic             ready,
    output logic [1:0]       cause
);

    localparam int unsigned HOLD_W = clog2_min1(HOLD_CYCLES + 1);
    localparam int unsigned STAG_W = clog2_min1(STAGGER);
    localparam int unsigned IDX_W  = clog2_min1(N_OUT);

    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLD_CYCLES);
    localparam logic [STAG_W-1:0] STAG_INIT = STAG_W'(STAGGER - 1);
    localparam logic [IDX_W-1:0]  IDX_FIRST = IDX_W'(1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N_OUT - 1);

    logic lock_s;

    // Declaration values match the reset values so power-up and reset look the same.
    rs_state_t         state_q    = RS_HOLD;
    rs_state_t         state_d;
    logic [HOLD_W-1:0] hold_cnt_q = HOLD_INIT;
    logic [HOLD_W-1:0] hold_cnt_d;
    logic [STAG_W-1:0] stag_q     = STAG_INIT;
    logic [STAG_W-1:0] stag_d;
    logic [IDX_W-1:0]  idx_q      = IDX_FIRST;
    logic [IDX_W-1:0]  idx_d;
    logic [N_OUT-1:0]  rst_out_q  = '1;
    logic [N_OUT-1:0]  rst_out_d;
    logic              ready_q    = 1'b0;
    logic              ready_d;
    rst_cause_t        cause_q    = RST_CAUSE_EXT;
    rst_cause_t        cause_d;

    logic              restart;
    logic              wdt_fire;

    sync_ff2 u_lock_sync (
        .clk (clk),
        .d   (pll_lock),
        .q   (lock_s)
    );

`ifdef RSTSEQ_WDT_EN
    localparam logic [WDT_W-1:0] WDT_MAX = '1;

    logic [WDT_W-1:0] wdt_q = '0;
    logic [WDT_W-1:0] wdt_d;

    // A kick on the expiry cycle wins over the timeout.
    assign wdt_fire = (state_q == RS_RUN) && wdt_en && !wdt_kick && (wdt_q == WDT_MAX);

    always_comb begin
        wdt_d = '0;
        if ((state_q == RS_RUN) && lock_s && !wdt_fire && !sw_rst_req && wdt_en && !wdt_kick) begin
            wdt_d = wdt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wdt_q <= '0;
        end else begin
            wdt_q <= wdt_d;
        end
    end
`else
    logic [WDT_W-1:0] wdt_unused;

    assign wdt_unused = {WDT_W{wdt_en ^ wdt_kick}};
    assign wdt_fire   = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        stag_d     = stag_q;
        idx_d      = idx_q;
        rst_out_d  = rst_out_q;
        ready_d    = ready_q;
        cause_d    = cause_q;
        restart    = 1'b0;

        case (state_q)
            RS_HOLD: begin
                if (!lock_s) begin
                    hold_cnt_d = HOLD_INIT;
                end else if (hold_cnt_q != '0) begin
                    hold_cnt_d = hold_cnt_q - 1'b1;
                end else begin
                    rst_out_d[0] = 1'b0;
                    if (N_OUT == 1) begin
                        state_d = RS_RUN;
                        ready_d = 1'b1;
                    end else begin
                        state_d = RS_RELEASE;
                        stag_d  = STAG_INIT;
                        idx_d   = IDX_FIRST;
                    end
                end
            end

            RS_RELEASE: begin
                if (!lock_s) begin
                    restart = 1'b1;
                    cause_d = RST_CAUSE_LOCK;
                end else if (stag_q != '0) begin
                    stag_d = stag_q - 1'b1;
                end else begin
                    rst_out_d[idx_q] = 1'b0;
                    stag_d           = STAG_INIT;
                    idx_d            = idx_q + 1'b1;
                    if (idx_q == IDX_LAST) begin
                        state_d = RS_RUN;
                        ready_d = 1'b1;
                    end
                end
            end

            RS_RUN: begin
                // Trigger priority: lock loss, then watchdog, then software request.
                if (!lock_s) begin
                    restart = 1'b1;
                    cause_d = RST_CAUSE_LOCK;
                end else if (wdt_fire) begin
                    restart = 1'b1;
                    cause_d = RST_CAUSE_WDT;
                end else if (sw_rst_req) begin
                    restart = 1'b1;
                    cause_d = RST_CAUSE_SW;
                end
            end

            default: begin
                restart = 1'b1;
            end
        endcase

        if (restart) begin
            state_d    = RS_HOLD;
            hold_cnt_d = HOLD_INIT;
            rst_out_d  = '1;
            ready_d    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= RS_HOLD;
            hold_cnt_q <= HOLD_INIT;
            stag_q     <= STAG_INIT;
            idx_q      <= IDX_FIRST;
            rst_out_q  <= '1;
            ready_q    <= 1'b0;
            cause_q    <= RST_CAUSE_EXT;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            stag_q     <= stag_d;
            idx_q      <= idx_d;
            rst_out_q  <= rst_out_d;
            ready_q    <= ready_d;
            cause_q    <= cause_d;
        end
    end

    assign rst_out = rst_out_q;
    assign ready   = ready_q;
    assign cause   = cause_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: directed vector table plus randomized traffic against a
// progress-time model. Watchdog expectations follow RSTSEQ_WDT_EN.
module tb_reset_sequencer;

    localparam int N_OUT  = 3;
    localparam int HOLD   = 10;
    localparam int STAG   = 3;
    localparam int WDT_W  = 4;
    localparam int T_FULL = HOLD + 1 + (N_OUT - 1) * STAG;
`ifdef RSTSEQ_WDT_EN
    localparam bit WDT_ON = 1'b1;
`else
    localparam bit WDT_ON = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             pll_lock = 1'b0;
    logic             sw_rst_req = 1'b0;
    logic             wdt_en = 1'b0;
    logic             wdt_kick = 1'b0;
    logic [N_OUT-1:0] rst_out;
    logic             ready;
    logic [1:0]       cause;

    int checks = 0;
    int errors = 0;

    // Model: m_t counts consecutive qualified-lock edges since the last restart.
    int m_t     = 0;
    int m_cause = 0;
    int m_wdt   = 0;
    bit m_s0    = 1'b0;
    bit m_s1    = 1'b0;

    typedef struct {
        int               n;
        bit               rst;
        bit               lock;
        bit               sw;
        bit               en;
        bit               kick;
        logic [N_OUT-1:0] e_rst;
        bit               e_ready;
        logic [1:0]       e_cause;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    reset_sequencer #(
        .N_OUT       (N_OUT),
        .HOLD_CYCLES (HOLD),
        .STAGGER     (STAG),
        .WDT_W       (WDT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pll_lock   (pll_lock),
        .sw_rst_req (sw_rst_req),
        .wdt_en     (wdt_en),
        .wdt_kick   (wdt_kick),
        .rst_out    (rst_out),
        .ready      (ready),
        .cause      (cause)
    );

    function automatic void add(int n, bit rst, bit lock, bit sw, bit en, bit kick,
                                logic [N_OUT-1:0] e_rst, bit e_ready, logic [1:0] e_cause);
        vec_t v;
        v.n = n; v.rst = rst; v.lock = lock; v.sw = sw; v.en = en; v.kick = kick;
        v.e_rst = e_rst; v.e_ready = e_ready; v.e_cause = e_cause;
        vecs.push_back(v);
    endfunction

    function automatic void model_edge();
        bit fire;
        if (reset) begin
            m_t = 0; m_cause = 0; m_wdt = 0;
        end else if (!m_s1) begin
            if (m_t >= HOLD + 1) m_cause = 1;
            m_t = 0; m_wdt = 0;
        end else if (m_t >= T_FULL) begin
            fire = WDT_ON && wdt_en && !wdt_kick && (m_wdt == (1 << WDT_W) - 1);
            if (fire) begin
                m_cause = 3; m_t = 0; m_wdt = 0;
            end else if (sw_rst_req) begin
                m_cause = 2; m_t = 0; m_wdt = 0;
            end else if (wdt_en && !wdt_kick) begin
                m_wdt++;
            end else begin
                m_wdt = 0;
            end
        end else begin
            m_t++; m_wdt = 0;
        end
        m_s1 = m_s0;
        m_s0 = pll_lock;
    endfunction

    task automatic check_model();
        logic [N_OUT-1:0] e;
        bit               er;
        for (int k = 0; k < N_OUT; k++) e[k] = !(m_t >= HOLD + 1 + k * STAG);
        er = (m_t >= T_FULL);
        checks++;
        if (rst_out !== e || ready !== er || cause !== 2'(m_cause)) begin
            errors++;
            $display("FAIL model t=%0t: got rst_out=%b ready=%b cause=%0d, want rst_out=%b ready=%b cause=%0d",
                     $time, rst_out, ready, cause, e, er, m_cause);
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check_model();
        sw_rst_req = 1'b0;
        wdt_kick   = 1'b0;
    endtask

    initial begin
        logic [1:0]       c_wd;
        logic [N_OUT-1:0] r_wd;
        bit               y_wd;
        int               n_wd;
        c_wd = WDT_ON ? 2'd3 : 2'd2;
        r_wd = WDT_ON ? 3'b111 : 3'b000;
        y_wd = !WDT_ON;
        n_wd = WDT_ON ? 9 : 10;

        //  n  rst lk sw en kk  rst_out  rdy cause
        add(3,  1, 0, 0, 0, 0, 3'b111, 0, 0);   // power-up held in reset
        add(12, 0, 1, 0, 0, 0, 3'b111, 0, 0);   // lock rises at T
        add(1,  0, 1, 0, 0, 0, 3'b110, 0, 0);   // T+13
        add(2,  0, 1, 0, 0, 0, 3'b110, 0, 0);
        add(1,  0, 1, 0, 0, 0, 3'b100, 0, 0);   // T+16
        add(2,  0, 1, 0, 0, 0, 3'b100, 0, 0);
        add(1,  0, 1, 0, 0, 0, 3'b000, 1, 0);   // T+19
        add(1,  0, 1, 1, 0, 0, 3'b111, 0, 2);   // sw request in RUN
        add(10, 0, 1, 0, 0, 0, 3'b111, 0, 2);
        add(1,  0, 1, 0, 0, 0, 3'b110, 0, 2);   // re-release 11 edges later
        add(2,  0, 0, 0, 0, 0, 3'b110, 0, 2);   // lock loss in RELEASE
        add(1,  0, 0, 0, 0, 0, 3'b111, 0, 1);
        add(12, 0, 1, 0, 0, 0, 3'b111, 0, 1);   // relock, full sequence again
        add(1,  0, 1, 0, 0, 0, 3'b110, 0, 1);
        add(6,  0, 1, 0, 0, 0, 3'b000, 1, 1);
        add(1,  0, 1, 1, 0, 0, 3'b111, 0, 2);
        add(5,  0, 1, 0, 0, 0, 3'b111, 0, 2);   // hold counter now at 5
        add(1,  0, 0, 0, 0, 0, 3'b111, 0, 2);   // one-cycle lock glitch
        add(12, 0, 1, 0, 0, 0, 3'b111, 0, 2);   // counter reloaded
        add(1,  0, 1, 0, 0, 0, 3'b110, 0, 2);
        add(6,  0, 1, 0, 0, 0, 3'b000, 1, 2);
        add(15, 0, 1, 0, 1, 0, 3'b000, 1, 2);   // watchdog reaches all ones
        add(1,  0, 1, 0, 1, 1, 3'b000, 1, 2);   // kick on expiry cycle wins
        add(15, 0, 1, 0, 1, 0, 3'b000, 1, 2);
        add(1,  0, 1, 0, 1, 0, r_wd, y_wd, c_wd);
        add(1,  0, 1, 1, 0, 0, 3'b111, 0, c_wd); // sw ignored in HOLD
        add(n_wd, 0, 1, 0, 0, 0, 3'b111, 0, c_wd);
        add(1,  0, 1, 0, 0, 0, 3'b110, 0, c_wd);
        add(1,  0, 1, 0, 0, 0, 3'b110, 0, c_wd);
        add(1,  1, 1, 1, 0, 0, 3'b111, 0, 0);   // reset beats sw in RELEASE
        add(10, 0, 1, 0, 0, 0, 3'b111, 0, 0);
        add(1,  0, 1, 0, 0, 0, 3'b110, 0, 0);
        add(6,  0, 1, 0, 0, 0, 3'b000, 1, 0);
        add(2,  0, 0, 0, 0, 0, 3'b000, 1, 0);   // lock loss in RUN
        add(1,  0, 0, 0, 0, 0, 3'b111, 0, 1);

        #1;
        foreach (vecs[i]) begin
            reset      = vecs[i].rst;
            pll_lock   = vecs[i].lock;
            wdt_en     = vecs[i].en;
            sw_rst_req = vecs[i].sw;
            wdt_kick   = vecs[i].kick;
            for (int j = 0; j < vecs[i].n; j++) step();
            checks++;
            if (rst_out !== vecs[i].e_rst || ready !== vecs[i].e_ready ||
                cause !== vecs[i].e_cause) begin
                errors++;
                $display("FAIL vec %0d: got rst_out=%b ready=%b cause=%0d, want rst_out=%b ready=%b cause=%0d",
                         i, rst_out, ready, cause, vecs[i].e_rst, vecs[i].e_ready, vecs[i].e_cause);
            end
        end

        reset    = 1'b0;
        pll_lock = 1'b1;
        wdt_en   = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 599) == 0);
            if (pll_lock) pll_lock = ($urandom_range(0, 299) != 0);
            else          pll_lock = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 99) == 0) wdt_en = !wdt_en;
            sw_rst_req = ($urandom_range(0, 199) == 0);
            wdt_kick   = ($urandom_range(0, 19) == 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
